change_dispenser: RTL and testbench

//  Downstream stage of vending_machine. Consumes the change amount (cng, qualified by pdt)
//  and the cancel refund (rtn, qualified by rtn_vld). Pays the amount from a two-tube coin

---
 rtl/change_dispenser.sv | 191 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin payout stage: pays change/refund from a 1-unit and a 2-unit tube using a 4-phase req/ack hopper.
// Optional audit counter of paid units is enabled by defining DISP_AUDIT_EN.
module change_dispenser #(
    parameter int AMT_W       = 3,
    parameter int CNT_W       = 8,
    parameter int INIT_ONE    = 16,
    parameter int INIT_TWO    = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdt,
    input  logic [AMT_W-1:0] cng,
    input  logic             rtn_vld,
    input  logic [AMT_W-1:0] rtn,
    input  logic             hop_ack,
    input  logic             refill_one,
    input  logic             refill_two,
    input  logic [CNT_W-1:0] refill_qty,
    input  logic             fault_clr,
    output logic             eject_one,
    output logic             eject_two,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             req_drop,
    output logic             fault,
    output logic [CNT_W-1:0] cnt_one,
    output logic [CNT_W-1:0] cnt_two,
    output logic [15:0]      paid_total
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [AMT_W-1:0] r_remaining;
    logic             r_coin_two;
    logic [TMR_W-1:0] r_timer;

    logic             w_accept_ack;
    logic             w_dec_one;
    logic             w_dec_two;
    logic [AMT_W-1:0] w_coin_val;

    assign w_accept_ack = (r_state == S_EJECT) && hop_ack;
    assign w_dec_two    = w_accept_ack && r_coin_two;
    assign w_dec_one    = w_accept_ack && !r_coin_two;
    assign w_coin_val   = r_coin_two ? AMT_W'(2) : AMT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_coin_two  <= 1'b0;
            r_timer     <= '0;
            eject_one   <= 1'b0;
            eject_two   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shortfall   <= '0;
            req_drop    <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; branches below raise them for one cycle only.
            done      <= 1'b0;
            shortfall <= '0;
            req_drop  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (pdt && (cng != '0)) begin
                        r_remaining <= cng;
                        r_state     <= S_SELECT;
                        busy        <= 1'b1;
                        req_drop    <= rtn_vld;
                    end else if (rtn_vld && (rtn != '0)) begin
                        r_remaining <= rtn;
                        r_state     <= S_SELECT;
                        busy        <= 1'b1;
                    end
                end
                S_SELECT: begin
                    r_timer <= '0;
                    if (r_remaining == '0) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else if ((r_remaining >= AMT_W'(2)) && (cnt_two != '0)) begin
                        r_coin_two <= 1'b1;
                        eject_two  <= 1'b1;
                        r_state    <= S_EJECT;
                    end else if (cnt_one != '0) begin
                        r_coin_two <= 1'b0;
                        eject_one  <= 1'b1;
                        r_state    <= S_EJECT;
                    end else begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        shortfall <= r_remaining;
                    end
                end
                S_EJECT: begin
                    if (hop_ack) begin
                        r_remaining <= r_remaining - w_coin_val;
                        eject_one   <= 1'b0;
                        eject_two   <= 1'b0;
                        r_state     <= S_GAP;
                    end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        r_remaining <= '0;
                        eject_one   <= 1'b0;
                        eject_two   <= 1'b0;
                        fault       <= 1'b1;
                        r_state     <= S_FAULT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (!hop_ack) begin
                        r_state <= S_SELECT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        fault   <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            if (r_state != S_IDLE) begin
                req_drop <= pdt || rtn_vld;
            end
        end
    end

    // Refill and decrement may land together; a decrement only follows a SELECT that saw cnt>0.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic             add,
                                                  input logic [CNT_W-1:0] qty,
                                                  input logic             dec);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (add ? {1'b0, qty} : {(CNT_W + 1){1'b0}})
            - {{CNT_W{1'b0}}, dec};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_one <= CNT_W'(INIT_ONE);
            cnt_two <= CNT_W'(INIT_TWO);
        end else begin
            cnt_one <= next_cnt(cnt_one, refill_one, refill_qty, w_dec_one);
            cnt_two <= next_cnt(cnt_two, refill_two, refill_qty, w_dec_two);
        end
    end

`ifdef DISP_AUDIT_EN
    logic [15:0] r_paid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_paid <= '0;
        end else if (w_accept_ack) begin
            r_paid <= r_paid + (r_coin_two ? 16'd2 : 16'd1);
        end
    end

    assign paid_total = r_paid;
`else
    assign paid_total = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, hand-written corner sequences,
// and randomized transactions checked against a closed-form greedy payout model.
module tb_change_dispenser;

    localparam int AMT_W = 3;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b0;
    logic             pdt = 1'b0, rtn_vld = 1'b0, hop_ack = 1'b0, fault_clr = 1'b0;
    logic [AMT_W-1:0] cng = '0, rtn = '0;
    logic             refill_one = 1'b0, refill_two = 1'b0;
    logic [CNT_W-1:0] refill_qty = '0;
    logic             eject_one, eject_two, busy, done, req_drop, fault;
    logic [AMT_W-1:0] shortfall;
    logic [CNT_W-1:0] cnt_one, cnt_two;
    logic [15:0]      paid_total;

    logic             b_pdt = 1'b0, b_hop_ack = 1'b0;
    logic [AMT_W-1:0] b_cng = '0;
    logic             b_eject_one, b_eject_two, b_busy, b_done, b_req_drop, b_fault;
    logic [AMT_W-1:0] b_shortfall;
    logic [CNT_W-1:0] b_cnt_one, b_cnt_two;
    logic [15:0]      b_paid_total;

    change_dispenser #(.ACK_TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .pdt(pdt), .cng(cng), .rtn_vld(rtn_vld), .rtn(rtn),
        .hop_ack(hop_ack), .refill_one(refill_one), .refill_two(refill_two),
        .refill_qty(refill_qty), .fault_clr(fault_clr), .eject_one(eject_one),
        .eject_two(eject_two), .busy(busy), .done(done), .shortfall(shortfall),
        .req_drop(req_drop), .fault(fault), .cnt_one(cnt_one), .cnt_two(cnt_two),
        .paid_total(paid_total)
    );

    change_dispenser #(.INIT_ONE(2), .INIT_TWO(0), .ACK_TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst), .pdt(b_pdt), .cng(b_cng), .rtn_vld(1'b0), .rtn(3'd0),
        .hop_ack(b_hop_ack), .refill_one(1'b0), .refill_two(1'b0),
        .refill_qty(8'd0), .fault_clr(1'b0), .eject_one(b_eject_one),
        .eject_two(b_eject_two), .busy(b_busy), .done(b_done), .shortfall(b_shortfall),
        .req_drop(b_req_drop), .fault(b_fault), .cnt_one(b_cnt_one), .cnt_two(b_cnt_two),
        .paid_total(b_paid_total)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Hopper responder: acks each request after a random short delay, or follows man_ack.
    logic hop_en  = 1'b1;
    logic man_ack = 1'b0;
    int   ack_wait = 0;
    int   n1 = 0, n2 = 0, nb1 = 0, nb2 = 0, both_seen = 0;

    initial forever begin
        @(negedge clk);
        if (eject_one && eject_two) both_seen++;
        if (hop_en) begin
            if ((eject_one || eject_two) && !hop_ack) begin
                if (ack_wait == 0) begin
                    hop_ack = 1'b1;
                    if (eject_two) n2++;
                    else n1++;
                end else begin
                    ack_wait--;
                end
            end else if (!eject_one && !eject_two && hop_ack) begin
                hop_ack  = 1'b0;
                ack_wait = $urandom_range(0, 2);
            end
        end else begin
            hop_ack = man_ack;
        end
        if ((b_eject_one || b_eject_two) && !b_hop_ack) begin
            b_hop_ack = 1'b1;
            if (b_eject_two) nb2++;
            else nb1++;
        end else if (!b_eject_one && !b_eject_two) begin
            b_hop_ack = 1'b0;
        end
    end

    // Reference model: greedy 2-first payout in closed form.
    int m_one = 16, m_two = 16, m_paid = 0;

    task automatic model_pay(input int amt, output int twos, output int ones, output int sf);
        twos   = (amt / 2 < m_two) ? amt / 2 : m_two;
        ones   = (amt - 2 * twos < m_one) ? amt - 2 * twos : m_one;
        sf     = amt - 2 * twos - ones;
        m_two  -= twos;
        m_one  -= ones;
        m_paid += 2 * twos + ones;
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    function automatic int exp_paid();
`ifdef DISP_AUDIT_EN
        return m_paid % 65536;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit got, output int sf);
        got = 1'b0;
        sf  = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got = 1'b1;
                sf  = int'(shortfall);
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic run_txn(input bit use_rtn, input int amt, output bit got, output int sf,
                           output int c1, output int c2);
        int n1_0, n2_0;
        n1_0 = n1;
        n2_0 = n2;
        if (use_rtn) begin
            rtn_vld = 1'b1;
            rtn     = AMT_W'(amt);
        end else begin
            pdt = 1'b1;
            cng = AMT_W'(amt);
        end
        tick();
        pdt     = 1'b0;
        rtn_vld = 1'b0;
        wait_done(got, sf);
        c1 = n1 - n1_0;
        c2 = n2 - n2_0;
    endtask

    typedef struct {
        bit use_rtn;
        int amt;
        int exp_two;
        int exp_one;
        int exp_sf;
        int exp_cnt_one;
        int exp_cnt_two;
    } vec_t;

    initial begin
        vec_t vecs[4];
        bit   got;
        int   sf, c1, c2, t2, t1, tsf, cyc;

        vecs[0] = '{0, 5, 2, 1, 0, 15, 14};
        vecs[1] = '{1, 3, 1, 1, 0, 14, 13};
        vecs[2] = '{0, 7, 3, 1, 0, 13, 10};
        vecs[3] = '{1, 1, 0, 1, 0, 12, 10};

        tick();
        tick();
        rst = 1'b1;
        tick();
        check("reset cnt_one", int'(cnt_one), 16);
        check("reset cnt_two", int'(cnt_two), 16);
        check("reset idle outputs", int'({eject_one, eject_two, busy, done, req_drop, fault}), 0);
        check("reset shortfall", int'(shortfall), 0);
        check("reset paid_total", int'(paid_total), 0);

        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v].use_rtn, vecs[v].amt, got, sf, c1, c2);
            model_pay(vecs[v].amt, t2, t1, tsf);
            check($sformatf("vec%0d done", v), int'(got), 1);
            check($sformatf("vec%0d two coins", v), c2, vecs[v].exp_two);
            check($sformatf("vec%0d one coins", v), c1, vecs[v].exp_one);
            check($sformatf("vec%0d shortfall", v), sf, vecs[v].exp_sf);
            check($sformatf("vec%0d cnt_one", v), int'(cnt_one), vecs[v].exp_cnt_one);
            check($sformatf("vec%0d cnt_two", v), int'(cnt_two), vecs[v].exp_cnt_two);
            check($sformatf("vec%0d done cleared", v), int'({done, shortfall, busy}), 0);
            check($sformatf("vec%0d paid_total", v), int'(paid_total), exp_paid());
        end

        // Latency: strobe edge N -> SELECT (busy, no eject) -> eject after N+1.
        pdt = 1'b1;
        cng = 3'd1;
        tick();
        pdt = 1'b0;
        check("latency busy after N", int'(busy), 1);
        check("latency no eject after N", int'(eject_one | eject_two), 0);
        tick();
        check("latency eject_one after N+1", int'(eject_one), 1);
        wait_done(got, sf);
        model_pay(1, t2, t1, tsf);
        check("latency txn shortfall", sf, 0);

        // Strobe while paying a refund is dropped with a one-cycle req_drop.
        c1 = n1;
        c2 = n2;
        rtn_vld = 1'b1;
        rtn     = 3'd3;
        tick();
        rtn_vld = 1'b0;
        pdt = 1'b1;
        cng = 3'd2;
        tick();
        pdt = 1'b0;
        check("req_drop on busy strobe", int'(req_drop), 1);
        tick();
        check("req_drop one cycle", int'(req_drop), 0);
        wait_done(got, sf);
        model_pay(3, t2, t1, tsf);
        check("refund 3 done", int'(got), 1);
        check("refund 3 coins", (n2 - c2) * 10 + (n1 - c1), 11);
        check("refund 3 cnt_two", int'(cnt_two), m_two);

        // Simultaneous strobes: product wins, refund is dropped.
        c1 = n1;
        c2 = n2;
        pdt = 1'b1;
        cng = 3'd1;
        rtn_vld = 1'b1;
        rtn = 3'd2;
        tick();
        pdt = 1'b0;
        rtn_vld = 1'b0;
        check("both strobes req_drop", int'(req_drop), 1);
        wait_done(got, sf);
        model_pay(1, t2, t1, tsf);
        check("both strobes paid cng", (n2 - c2) * 10 + (n1 - c1), 1);

        // Zero amount is ignored.
        pdt = 1'b1;
        cng = 3'd0;
        tick();
        pdt = 1'b0;
        check("zero amount stays idle", int'(busy), 0);
        tick();
        check("zero amount no done", int'(done), 0);

        // Hopper never acks: eject held ACK_TIMEOUT cycles, then fault.
        hop_en = 1'b0;
        pdt = 1'b1;
        cng = 3'd2;
        tick();
        pdt = 1'b0;
        cyc = 0;
        for (int i = 0; i < 12 && !fault; i++) begin
            tick();
            if (eject_two) cyc++;
        end
        check("timeout eject cycles", cyc, 4);
        check("timeout fault", int'(fault), 1);
        check("timeout eject low", int'(eject_one | eject_two), 0);
        check("timeout cnt_two unchanged", int'(cnt_two), m_two);
        check("timeout cnt_one unchanged", int'(cnt_one), m_one);
        tick();
        check("fault held", int'(fault), 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fault cleared", int'({fault, busy}), 0);
        hop_en = 1'b1;

        // Saturation: refill to full, pay one 2-coin, then refill lands with a 2-coin ack.
        refill_two = 1'b1;
        refill_qty = 8'd255;
        tick();
        refill_two = 1'b0;
        m_two = sat_add(m_two, 255);
        check("refill saturates", int'(cnt_two), 255);
        run_txn(0, 2, got, sf, c1, c2);
        model_pay(2, t2, t1, tsf);
        check("cnt_two before collision", int'(cnt_two), 254);
        hop_en = 1'b0;
        pdt = 1'b1;
        cng = 3'd2;
        tick();
        pdt = 1'b0;
        tick();
        check("collision eject_two", int'(eject_two), 1);
        man_ack = 1'b1;
        refill_two = 1'b1;
        refill_qty = 8'd5;
        tick();
        refill_two = 1'b0;
        man_ack = 1'b0;
        check("refill+dec saturates", int'(cnt_two), 255);
        m_two = 255;
        m_paid += 2;
        wait_done(got, sf);
        check("collision txn done", int'(got), 1);
        hop_en = 1'b1;
        check("paid_total after directed", int'(paid_total), exp_paid());

        // Second instance: empty 2-tube, two 1-coins, shortfall of 3.
        b_pdt = 1'b1;
        b_cng = 3'd5;
        tick();
        b_pdt = 1'b0;
        got = 1'b0;
        sf = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            if (b_done) begin
                got = 1'b1;
                sf  = int'(b_shortfall);
            end else begin
                tick();
            end
        end
        check("empty tube done", int'(got), 1);
        check("empty tube shortfall", sf, 3);
        check("empty tube one coins", nb1 * 10 + nb2, 20);
        check("empty tube cnt_one", int'(b_cnt_one), 0);

        // Randomized transactions with occasional refills.
        for (int r = 0; r < 30; r++) begin
            int amt;
            bit use_rtn;
            if ($urandom_range(0, 3) == 0) begin
                refill_qty = CNT_W'($urandom_range(0, 20));
                refill_one = 1'($urandom_range(0, 1));
                refill_two = 1'($urandom_range(0, 1));
                tick();
                if (refill_one) m_one = sat_add(m_one, int'(refill_qty));
                if (refill_two) m_two = sat_add(m_two, int'(refill_qty));
                refill_one = 1'b0;
                refill_two = 1'b0;
            end
            amt     = $urandom_range(1, 7);
            use_rtn = 1'($urandom_range(0, 1));
            run_txn(use_rtn, amt, got, sf, c1, c2);
            model_pay(amt, t2, t1, tsf);
            check($sformatf("rnd%0d done", r), int'(got), 1);
            check($sformatf("rnd%0d amt%0d shortfall", r, amt), sf, tsf);
            check($sformatf("rnd%0d coins", r), c2 * 10 + c1, t2 * 10 + t1);
            check($sformatf("rnd%0d cnt_one", r), int'(cnt_one), m_one);
            check($sformatf("rnd%0d cnt_two", r), int'(cnt_two), m_two);
            check($sformatf("rnd%0d paid_total", r), int'(paid_total), exp_paid());
        end

        check("eject never both", both_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
